// File: rtl/ntt_stage_sequencer_if.sv
// ntt_stage_sequencer_if: start/config inputs and per-beat butterfly outputs of the NTT stage sequencer.
interface ntt_stage_sequencer_if #(
  parameter int LOG_N_MAX = 10,
  parameter int LANES = 4
);
  logic i_start;
  logic [3:0] i_log_n;
  logic i_inverse;
  logic i_ready;
  logic o_valid;
  logic [3:0] o_stage;
  logic [LANES*LOG_N_MAX-1:0] o_addr_lo;
  logic [LANES*LOG_N_MAX-1:0] o_addr_hi;
  logic [LANES*(LOG_N_MAX-1)-1:0] o_twiddle;
  logic o_busy;
  logic o_done;
  logic o_err;
  modport master (
    input i_start, i_log_n, i_inverse, i_ready,
    output o_valid, o_stage, o_addr_lo, o_addr_hi, o_twiddle, o_busy, o_done, o_err
  );
  modport slave (
    output i_start, i_log_n, i_inverse, i_ready,
    input o_valid, o_stage, o_addr_lo, o_addr_hi, o_twiddle, o_busy, o_done, o_err
  );
endinterface

// File: rtl/ntt_stage_sequencer.sv
// ntt_stage_sequencer: walks every radix-2 stage of an in-place NTT, issuing LANES butterfly pairs per beat.
module ntt_stage_sequencer #(
  parameter int LOG_N_MAX = 10,
  parameter int LANES = 4,
  parameter int DRAIN = 6
) (
  input logic clock,
  input logic i_reset_n,
  ntt_stage_sequencer_if.master bus
);
  localparam int ADDR_W = LOG_N_MAX;
  localparam int TW_W = ADDR_W - 1;
  localparam int DC_W = $clog2(DRAIN + 1);
  localparam logic [3:0] L_MIN = 4'($clog2(LANES) + 1);
  localparam logic [3:0] L_MAX = 4'(LOG_N_MAX);
  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);
  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;
  state_t state, state_nx;
  logic [3:0] log_n, stage, h, tsh;
  logic inverse, err, legal, accept, valid, fire, last_beat, drain_end, last_stage;
  logic [ADDR_W-1:0] base, half, mask, b, j, lo;
  logic [TW_W-1:0] tw;
  logic [DC_W-1:0] drain_cnt;
  logic [LANES*ADDR_W-1:0] lo_w, hi_w;
  logic [LANES*TW_W-1:0] tw_w;
  assign legal = bus.i_log_n >= L_MIN && bus.i_log_n <= L_MAX;
  assign accept = state == S_IDLE && bus.i_start && legal;
  assign valid = state == S_ISSUE;
  assign fire = valid && bus.i_ready;
  assign last_beat = base + ADDR_W'(LANES) == ONE << (log_n - 4'd1);
  assign drain_end = drain_cnt == DC_W'(DRAIN - 1);
  assign last_stage = stage == log_n - 4'd1;
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: state_nx = accept ? S_ISSUE : S_IDLE;
      S_ISSUE: state_nx = fire && last_beat ? S_DRAIN : S_ISSUE;
      S_DRAIN: state_nx = !drain_end ? S_DRAIN : last_stage ? S_DONE : S_ISSUE;
      default: state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge i_reset_n)
    if (!i_reset_n) state <= S_IDLE;
    else state <= state_nx;
  always_ff @(posedge clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      log_n <= '0;
      inverse <= 1'b0;
      stage <= '0;
      base <= '0;
      drain_cnt <= '0;
      err <= 1'b0;
    end else begin
      err <= state == S_IDLE && bus.i_start && !legal;
      drain_cnt <= state == S_DRAIN ? drain_cnt + DC_W'(1) : '0;
      if (accept) begin
        log_n <= bus.i_log_n;
        inverse <= bus.i_inverse;
        stage <= '0;
        base <= '0;
      end
      if (fire) base <= last_beat ? '0 : base + ADDR_W'(LANES);
      if (state == S_DRAIN && drain_end && !last_stage) stage <= stage + 4'd1;
    end
  end
  // half is a power of two, so g/j split is a mask and lo = 2*g*half + j is a one-bit shift of the g field
  assign h = inverse ? stage : log_n - 4'd1 - stage;
  assign tsh = inverse ? log_n - 4'd1 - stage : stage;
  assign half = ONE << h;
  assign mask = half - ONE;
  always_comb begin
    lo_w = '0;
    hi_w = '0;
    tw_w = '0;
    b = '0;
    j = '0;
    lo = '0;
    tw = '0;
    for (int k = 0; k < LANES; k++) begin
      b = base + ADDR_W'(k);
      j = b & mask;
      lo = ((b & ~mask) << 1) | j;
      tw = TW_W'(j << tsh);
      lo_w[k*ADDR_W +: ADDR_W] = lo;
      hi_w[k*ADDR_W +: ADDR_W] = lo | half;
      tw_w[k*TW_W +: TW_W] = tw;
    end
  end
  assign bus.o_valid = valid;
  assign bus.o_stage = stage;
  assign bus.o_addr_lo = valid ? lo_w : '0;
  assign bus.o_addr_hi = valid ? hi_w : '0;
  assign bus.o_twiddle = valid ? tw_w : '0;
  assign bus.o_busy = state != S_IDLE;
  assign bus.o_done = state == S_DONE;
  assign bus.o_err = err;
endmodule
